// File: rtl/trig_seq_busy_pkg.sv
// Shared definitions for the trigger-sequence busy tracker: state encoding and default widths.
// Imported by the interface, the top level and the testbench.
package trig_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_L1 = 3'd1,
      WAIT_L2 = 3'd2,
      READOUT = 3'd3,
      HOLDOFF = 3'd4
   } state_t;

   localparam int DEF_EVT_W = 24;
   localparam int DEF_ERR_W = 16;
   localparam int DEF_TMO_W = 16;

endpackage

// File: rtl/trig_seq_busy_if.sv
// Trigger inputs, window configuration and status outputs of the busy tracker.
// The master side drives triggers and configuration; the slave side is the tracker itself.
interface trig_seq_busy_if
   import trig_seq_pkg::*;
#(
   parameter int EVT_W = DEF_EVT_W,
   parameter int ERR_W = DEF_ERR_W,
   parameter int TMO_W = DEF_TMO_W
);

   logic             l0;
   logic             l1;
   logic             l2a;
   logic [TMO_W-1:0] l1_window;
   logic [TMO_W-1:0] l2_window;
   logic [TMO_W-1:0] holdoff_len;
   logic             readout_done;
   logic             clr_cnt;

   logic             busy_flag;
   logic             evt_accept;
   logic             seq_err;
   logic [EVT_W-1:0] evt_cnt;
   logic [ERR_W-1:0] l1_tmo_cnt;
   logic [ERR_W-1:0] l2_tmo_cnt;
   logic [ERR_W-1:0] seq_err_cnt;
   logic [2:0]       state_o;

   modport master (
      output l0, l1, l2a, l1_window, l2_window, holdoff_len, readout_done, clr_cnt,
      input  busy_flag, evt_accept, seq_err, evt_cnt, l1_tmo_cnt, l2_tmo_cnt,
             seq_err_cnt, state_o
   );

   modport slave (
      input  l0, l1, l2a, l1_window, l2_window, holdoff_len, readout_done, clr_cnt,
      output busy_flag, evt_accept, seq_err, evt_cnt, l1_tmo_cnt, l2_tmo_cnt,
             seq_err_cnt, state_o
   );

endinterface

// File: rtl/trig_seq_busy_sat_counter.sv
// Event/error counter with synchronous clear; SATURATE selects sticking at all-ones
// instead of wrapping back to zero.
module sat_counter #(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;
   logic             w_atMax;

   assign w_atMax = SATURATE && (r_count == '1);

   // Clear takes priority over a coincident increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && !w_atMax) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/trig_seq_busy.sv
// Follows each L0/L1/L2a trigger sequence, enforces the L1/L2 arrival windows and
// drives the registered busy flag back to the trigger generator, plus status counters.
module trig_seq_busy
   import trig_seq_pkg::*;
#(
   parameter int EVT_W = DEF_EVT_W,
   parameter int ERR_W = DEF_ERR_W,
   parameter int TMO_W = DEF_TMO_W
) (
   input logic             gclk_40m,
   input logic             reset,
   trig_seq_busy_if.slave  bus
);

   state_t           r_state;
   state_t           w_next;
   logic [TMO_W-1:0] r_waitCnt;
   logic [TMO_W-1:0] w_waitCntNext;
   logic             r_busy;
   logic             r_evtAccept;
   logic             r_seqErr;

   logic             w_seqErr;
   logic             w_accept;
   logic             w_l1Tmo;
   logic             w_l2Tmo;
   logic             w_l1Expire;
   logic             w_l2Expire;
   logic             w_holdDone;

   logic [EVT_W-1:0] w_evtCnt;
   logic [ERR_W-1:0] w_l1TmoCnt;
   logic [ERR_W-1:0] w_l2TmoCnt;
   logic [ERR_W-1:0] w_seqErrCnt;

   // A zero window never expires; the wait counter is free to wrap in that case
   assign w_l1Expire = (bus.l1_window != '0) && (r_waitCnt == bus.l1_window - TMO_W'(1));
   assign w_l2Expire = (bus.l2_window != '0) && (r_waitCnt == bus.l2_window - TMO_W'(1));
   assign w_holdDone = (bus.holdoff_len == '0) || (r_waitCnt == bus.holdoff_len - TMO_W'(1));

   always_comb begin
      w_next        = r_state;
      w_waitCntNext = r_waitCnt + TMO_W'(1);
      w_seqErr      = 1'b0;
      w_accept      = 1'b0;
      w_l1Tmo       = 1'b0;
      w_l2Tmo       = 1'b0;
      case (r_state)
         IDLE: begin
            w_waitCntNext = '0;
            w_seqErr      = bus.l1 | bus.l2a;
            if (bus.l0) w_next = WAIT_L1;
         end
         // The expected trigger beats a coincident expiry
         WAIT_L1: begin
            w_seqErr = bus.l0 | bus.l2a;
            if (bus.l1) begin
               w_next        = WAIT_L2;
               w_waitCntNext = '0;
            end else if (w_l1Expire) begin
               w_next        = HOLDOFF;
               w_waitCntNext = '0;
               w_l1Tmo       = 1'b1;
            end
         end
         WAIT_L2: begin
            w_seqErr = bus.l0 | bus.l1;
            if (bus.l2a) begin
               w_next        = READOUT;
               w_waitCntNext = '0;
               w_accept      = 1'b1;
            end else if (w_l2Expire) begin
               w_next        = HOLDOFF;
               w_waitCntNext = '0;
               w_l2Tmo       = 1'b1;
            end
         end
         READOUT: begin
            w_waitCntNext = '0;
            w_seqErr      = bus.l0 | bus.l1 | bus.l2a;
            if (bus.readout_done) w_next = HOLDOFF;
         end
         HOLDOFF: begin
            w_seqErr = bus.l0 | bus.l1 | bus.l2a;
            if (w_holdDone) begin
               w_next        = IDLE;
               w_waitCntNext = '0;
            end
         end
         default: begin
            w_next        = IDLE;
            w_waitCntNext = '0;
         end
      endcase
   end

   // Busy is taken from the next state so it rises on the same edge that samples L0
   always_ff @(posedge gclk_40m or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_waitCnt   <= '0;
         r_busy      <= 1'b0;
         r_evtAccept <= 1'b0;
         r_seqErr    <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_waitCnt   <= w_waitCntNext;
         r_busy      <= (w_next != IDLE);
         r_evtAccept <= w_accept;
         r_seqErr    <= w_seqErr;
      end
   end

   sat_counter #(.WIDTH(EVT_W), .SATURATE(1'b0)) u_evtCnt (
      .clk(gclk_40m), .rst(reset), .i_inc(w_accept), .i_clr(bus.clr_cnt), .o_count(w_evtCnt)
   );

   sat_counter #(.WIDTH(ERR_W), .SATURATE(1'b1)) u_l1TmoCnt (
      .clk(gclk_40m), .rst(reset), .i_inc(w_l1Tmo), .i_clr(bus.clr_cnt), .o_count(w_l1TmoCnt)
   );

   sat_counter #(.WIDTH(ERR_W), .SATURATE(1'b1)) u_l2TmoCnt (
      .clk(gclk_40m), .rst(reset), .i_inc(w_l2Tmo), .i_clr(bus.clr_cnt), .o_count(w_l2TmoCnt)
   );

   sat_counter #(.WIDTH(ERR_W), .SATURATE(1'b1)) u_seqErrCnt (
      .clk(gclk_40m), .rst(reset), .i_inc(w_seqErr), .i_clr(bus.clr_cnt), .o_count(w_seqErrCnt)
   );

   assign bus.busy_flag   = r_busy;
   assign bus.evt_accept  = r_evtAccept;
   assign bus.seq_err     = r_seqErr;
   assign bus.evt_cnt     = w_evtCnt;
   assign bus.l1_tmo_cnt  = w_l1TmoCnt;
   assign bus.l2_tmo_cnt  = w_l2TmoCnt;
   assign bus.seq_err_cnt = w_seqErrCnt;
   assign bus.state_o     = r_state;

endmodule

// File: tb/tb_trig_seq_busy.sv
// Directed testbench for trig_seq_busy; a second instance with 4-bit error counters
// shares the same stimulus so that saturation can be reached in a short run.
module tb_trig_seq_busy;
   import trig_seq_pkg::*;

   logic gclk_40m = 1'b0;
   logic reset;
   int   nChecks = 0;
   int   nFails  = 0;

   trig_seq_busy_if bus ();
   trig_seq_busy_if #(.ERR_W(4)) satBus ();

   assign satBus.l0           = bus.l0;
   assign satBus.l1           = bus.l1;
   assign satBus.l2a          = bus.l2a;
   assign satBus.l1_window    = bus.l1_window;
   assign satBus.l2_window    = bus.l2_window;
   assign satBus.holdoff_len  = bus.holdoff_len;
   assign satBus.readout_done = bus.readout_done;
   assign satBus.clr_cnt      = bus.clr_cnt;

   trig_seq_busy u_dut (
      .gclk_40m (gclk_40m),
      .reset    (reset),
      .bus      (bus)
   );

   trig_seq_busy #(.ERR_W(4)) u_dutSat (
      .gclk_40m (gclk_40m),
      .reset    (reset),
      .bus      (satBus)
   );

   always #12 gclk_40m = ~gclk_40m;

   // Outputs are observed 1 time unit after the rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge gclk_40m);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic l0, input logic l1, input logic l2a,
                                input logic done, input logic clr);
      bus.l0           = l0;
      bus.l1           = l1;
      bus.l2a          = l2a;
      bus.readout_done = done;
      bus.clr_cnt      = clr;
      tick(1);
      bus.l0           = 1'b0;
      bus.l1           = 1'b0;
      bus.l2a          = 1'b0;
      bus.readout_done = 1'b0;
      bus.clr_cnt      = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp)
      else begin
         nFails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.l0           = 1'b0;
      bus.l1           = 1'b0;
      bus.l2a          = 1'b0;
      bus.readout_done = 1'b0;
      bus.clr_cnt      = 1'b0;
      bus.l1_window    = 16'd10;
      bus.l2_window    = 16'd50;
      bus.holdoff_len  = 16'd3;
      reset            = 1'b1;
      tick(2);
      checkOutput("rst_busy", bus.busy_flag, 0);
      checkOutput("rst_state", bus.state_o, 0);
      checkOutput("rst_evt_cnt", bus.evt_cnt, 0);
      checkOutput("rst_seq_err_cnt", bus.seq_err_cnt, 0);
      reset = 1'b0;
      tick(1);

      // Full sequence: l0 @0, l1 @5, l2a @30, readout_done @40, holdoff 3
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t1_busy_after_l0", bus.busy_flag, 1);
      checkOutput("t1_state_wait_l1", bus.state_o, 1);
      tick(4);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("t1_state_wait_l2", bus.state_o, 2);
      tick(24);
      checkOutput("t1_still_wait_l2", bus.state_o, 2);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("t1_state_readout", bus.state_o, 3);
      checkOutput("t1_evt_accept", bus.evt_accept, 1);
      checkOutput("t1_evt_cnt", bus.evt_cnt, 1);
      tick(1);
      checkOutput("t1_evt_accept_drop", bus.evt_accept, 0);
      tick(8);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("t1_state_holdoff", bus.state_o, 4);
      tick(2);
      checkOutput("t1_busy_cycle43", bus.busy_flag, 1);
      tick(1);
      checkOutput("t1_busy_cycle44", bus.busy_flag, 0);
      checkOutput("t1_state_idle", bus.state_o, 0);
      checkOutput("t1_l1_tmo_cnt", bus.l1_tmo_cnt, 0);
      checkOutput("t1_l2_tmo_cnt", bus.l2_tmo_cnt, 0);
      checkOutput("t1_seq_err_cnt", bus.seq_err_cnt, 0);

      // L1 timeout after exactly 8 wait cycles, holdoff 0
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("t2_clr_evt_cnt", bus.evt_cnt, 0);
      bus.l1_window   = 16'd8;
      bus.l2_window   = 16'd2;
      bus.holdoff_len = 16'd0;
      applyStimulus(1, 0, 0, 0, 0);
      tick(7);
      checkOutput("t2_wait_cycle8", bus.state_o, 1);
      tick(1);
      checkOutput("t2_state_holdoff", bus.state_o, 4);
      checkOutput("t2_l1_tmo_cnt", bus.l1_tmo_cnt, 1);
      checkOutput("t2_evt_cnt", bus.evt_cnt, 0);
      tick(1);
      checkOutput("t2_holdoff0_idle", bus.state_o, 0);

      // Rerun with l1 in the expiry cycle, then let the 2-cycle L2 window lapse
      applyStimulus(1, 0, 0, 0, 0);
      tick(7);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("t2_l1_edge_wins", bus.state_o, 2);
      checkOutput("t2_no_extra_tmo", bus.l1_tmo_cnt, 1);
      tick(1);
      checkOutput("t2_l2_wait", bus.state_o, 2);
      tick(1);
      checkOutput("t2_l2_expired", bus.state_o, 4);
      checkOutput("t2_l2_tmo_cnt", bus.l2_tmo_cnt, 1);
      tick(1);
      checkOutput("t2_back_idle", bus.state_o, 0);

      // Out-of-sequence triggers
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("t3_seq_err_l1_idle", bus.seq_err, 1);
      checkOutput("t3_state_idle", bus.state_o, 0);
      checkOutput("t3_seq_err_cnt1", bus.seq_err_cnt, 1);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("t3_seq_err_l0_l2a", bus.seq_err, 1);
      checkOutput("t3_state_wait_l1", bus.state_o, 1);
      checkOutput("t3_seq_err_cnt2", bus.seq_err_cnt, 2);
      tick(1);
      checkOutput("t3_seq_err_drop", bus.seq_err, 0);

      // Zero L2 window waits indefinitely
      bus.l2_window = 16'd0;
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("t4_state_wait_l2", bus.state_o, 2);
      tick(69999);
      checkOutput("t4_still_wait_l2", bus.state_o, 2);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("t4_state_readout", bus.state_o, 3);
      checkOutput("t4_evt_cnt", bus.evt_cnt, 1);
      checkOutput("t4_l2_tmo_cnt", bus.l2_tmo_cnt, 0);

      // Asynchronous reset in READOUT, observed before the next edge
      checkOutput("t6_busy_before", bus.busy_flag, 1);
      reset = 1'b1;
      #2;
      checkOutput("t6_busy_async", bus.busy_flag, 0);
      checkOutput("t6_state_async", bus.state_o, 0);
      checkOutput("t6_evt_cnt_async", bus.evt_cnt, 0);
      checkOutput("t6_seq_err_cnt_async", bus.seq_err_cnt, 0);
      checkOutput("t6_l2_tmo_async", bus.l2_tmo_cnt, 0);
      reset = 1'b0;
      #1;
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t6_l0_after_reset", bus.state_o, 1);
      checkOutput("t6_busy_after_reset", bus.busy_flag, 1);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("t6_evt_cnt", bus.evt_cnt, 1);
      applyStimulus(0, 0, 0, 1, 0);
      tick(1);
      checkOutput("t6_back_idle", bus.state_o, 0);

      // Saturation on the 4-bit instance, then clear racing an expiry
      bus.l1_window   = 16'd1;
      bus.holdoff_len = 16'd0;
      applyStimulus(0, 0, 0, 0, 1);
      repeat (20) begin
         applyStimulus(1, 0, 0, 0, 0);
         tick(2);
      end
      checkOutput("t5_l1_tmo_cnt_wide", bus.l1_tmo_cnt, 20);
      checkOutput("t5_l1_tmo_cnt_sat", satBus.l1_tmo_cnt, 15);
      checkOutput("t5_state_idle", bus.state_o, 0);
      checkOutput("t5_seq_err_cnt", bus.seq_err_cnt, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("t5_clr_state_holdoff", bus.state_o, 4);
      checkOutput("t5_clr_wins_wide", bus.l1_tmo_cnt, 0);
      checkOutput("t5_clr_wins_sat", satBus.l1_tmo_cnt, 0);
      tick(1);
      applyStimulus(1, 0, 0, 0, 0);
      tick(2);
      checkOutput("t5_count_after_clr", satBus.l1_tmo_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
